// File: rtl/core_pkg.sv
// Purpose: shared types and constants for the fetch stage (FSM states, PC mux select, NOP word, PC step).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
   localparam int unsigned PC_STEP   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } fetch_state_e;

   // Next-PC mux select driven by the fetch FSM.
   typedef enum logic [1:0] {
      PC_HOLD,
      PC_INC,
      PC_REDIR
   } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Purpose: bundles the instruction-memory, redirect and decode handshake signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: instr_ready from decode holds the fetched instruction; imem_gnt stalls the request.
// Modports: master = fetch stage, slave = memory/decode/redirect side.
interface instruction_fetch_if #(
   parameter int unsigned Width = 32
);
   // instruction memory read port
   logic             imem_req;
   logic [Width-1:0] imem_addr;
   logic             imem_gnt;
   logic             imem_rvalid;
   logic [Width-1:0] imem_rdata;
   // redirect from the branch/jump unit
   logic             redirect;
   logic [Width-1:0] redirect_pc;
   // decode handshake
   logic             instr_valid;
   logic [Width-1:0] instr;
   logic [Width-1:0] instr_pc;
   logic             instr_ready;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );

endinterface

// File: rtl/fetch_pc_reg.sv
// Purpose: program counter register with +4 incrementer, word-alignment masking and hold/+4/redirect mux.
// Latency: new PC visible one cycle after sel_i is applied.
// Backpressure: none; PC_HOLD keeps the current value.
// Ports: clk, rst_n, sel_i (mux select), redirect_pc_i (target, low bits ignored), pc_o (current PC).
module fetch_pc_reg
   import core_pkg::*;
#(
   parameter int unsigned      Width   = 32,
   parameter logic [Width-1:0] ResetPC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  pc_sel_e          sel_i,
   input  logic [Width-1:0] redirect_pc_i,
   output logic [Width-1:0] pc_o
);

   localparam logic [Width-1:0] ALIGN_MASK = ~Width'(3);

   logic [Width-1:0] pc_q;
   logic [Width-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      case (sel_i)
         PC_INC:   pc_d = pc_q + Width'(PC_STEP);  // wraps modulo 2^Width
         PC_REDIR: pc_d = redirect_pc_i & ALIGN_MASK;
         default:  pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= ResetPC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Purpose: fetch stage FSM; one outstanding word read, hands instruction + PC to decode, flushes on redirect.
// Latency: reset release to instr_valid is 3 cycles; 3 cycles per instruction with zero-wait memory.
// Backpressure: instr_ready low holds instr/instr_pc stable in HOLD and no new request is issued.
// Ports: clk, rst_n (async active-low), fetch_if (master modport: imem read port, redirect, decode handshake).
module instruction_fetch
   import core_pkg::*;
#(
   parameter int unsigned      Width   = 32,
   parameter logic [Width-1:0] ResetPC = '0
) (
   input logic                 clk,
   input logic                 rst_n,
   instruction_fetch_if.master fetch_if
);

   fetch_state_e     state_q, state_d;
   logic             kill_q, kill_d;      // outstanding response belongs to a flushed path
   logic [Width-1:0] instr_q, instr_d;
   logic [Width-1:0] instr_pc_q, instr_pc_d;
   pc_sel_e          pc_sel;
   logic [Width-1:0] pc;

   fetch_pc_reg #(
      .Width   (Width),
      .ResetPC (ResetPC)
   ) u_pc (
      .clk           (clk),
      .rst_n         (rst_n),
      .sel_i         (pc_sel),
      .redirect_pc_i (fetch_if.redirect_pc),
      .pc_o          (pc)
   );

   always_comb begin
      state_d    = state_q;
      kill_d     = kill_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      pc_sel     = PC_HOLD;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end

         ST_REQ: begin
            if (fetch_if.imem_gnt) begin
               state_d = ST_WAIT;
               // The granted read is for the old path; its response must be dropped.
               if (fetch_if.redirect) begin
                  pc_sel = PC_REDIR;
                  kill_d = 1'b1;
               end
            end else if (fetch_if.redirect) begin
               pc_sel = PC_REDIR;
            end
         end

         ST_WAIT: begin
            if (fetch_if.imem_rvalid) begin
               if (kill_q || fetch_if.redirect) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
                  if (fetch_if.redirect) begin
                     pc_sel = PC_REDIR;
                  end
               end else begin
                  instr_d    = fetch_if.imem_rdata;
                  instr_pc_d = pc;
                  pc_sel     = PC_INC;
                  state_d    = ST_HOLD;
               end
            end else if (fetch_if.redirect) begin
               // Stay until the stale response drains, then request the target.
               pc_sel = PC_REDIR;
               kill_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (fetch_if.redirect) begin
               pc_sel  = PC_REDIR;
               state_d = ST_REQ;
            end else if (fetch_if.instr_ready) begin
               state_d = ST_REQ;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         kill_q     <= 1'b0;
         instr_q    <= Width'(NOP_INSTR);
         instr_pc_q <= ResetPC;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   // Outputs come from registers or state decode only.
   assign fetch_if.imem_req    = (state_q == ST_REQ);
   assign fetch_if.imem_addr   = pc;
   assign fetch_if.instr_valid = (state_q == ST_HOLD);
   assign fetch_if.instr       = instr_q;
   assign fetch_if.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose: self-checking bench for instruction_fetch with a memory responder and an instruction-stream model.
// Latency: n/a.
// Backpressure: instr_ready and imem_gnt are driven directed or randomly.
module tb_instruction_fetch;
   import core_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   instruction_fetch_if #(.Width(32)) bus ();

   instruction_fetch #(
      .Width   (32),
      .ResetPC (RESET_PC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetch_if (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // memory responder
   bit          gnt_rand = 1'b0;
   int          lat_min  = 1;
   int          lat_max  = 1;
   bit          pend     = 1'b0;
   int          cnt      = 0;
   logic [31:0] paddr    = '0;

   // instruction stream model: accepted instructions are sequential from the last redirect target
   bit          chk_en    = 1'b0;
   logic [31:0] exp_pc    = RESET_PC;
   logic [31:0] acc_q[$];
   bit          hold_pend = 1'b0;
   logic [31:0] hold_instr, hold_pc;

   function automatic logic [31:0] memw(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
   endfunction

   // One clock: model checks on current values, edge, then responder update.
   task automatic cycle();
      bit          granted;
      bit          acc;
      logic [31:0] gaddr;
      granted = bus.imem_req && bus.imem_gnt && rst_n;
      gaddr   = bus.imem_addr;
      if (chk_en) begin
         if (hold_pend) begin
            n_chk++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== hold_instr || bus.instr_pc !== hold_pc) begin
               n_fail++;
               $display("FAIL hold_stable: got valid=%b instr=%h pc=%h, want valid=1 instr=%h pc=%h",
                        bus.instr_valid, bus.instr, bus.instr_pc, hold_instr, hold_pc);
            end
         end
         if (bus.imem_req) begin
            n_chk++;
            if (pend) begin
               n_fail++;
               $display("FAIL one_outstanding: request at %h while a response is pending", bus.imem_addr);
            end
         end
         acc = bus.instr_valid && bus.instr_ready && !bus.redirect;
         if (acc) begin
            n_chk++;
            if (bus.instr_pc !== exp_pc || bus.instr !== memw(exp_pc)) begin
               n_fail++;
               $display("FAIL stream: got pc=%h instr=%h, want pc=%h instr=%h",
                        bus.instr_pc, bus.instr, exp_pc, memw(exp_pc));
            end
            acc_q.push_back(bus.instr_pc);
            exp_pc = exp_pc + 32'd4;
         end
         if (bus.redirect) exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
         hold_pend  = bus.instr_valid && !bus.instr_ready && !bus.redirect;
         hold_instr = bus.instr;
         hold_pc    = bus.instr_pc;
      end
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom();
      if (granted) begin
         pend  = 1'b1;
         cnt   = int'($urandom_range(lat_min, lat_max));
         paddr = gaddr;
      end
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memw(paddr);
            pend            = 1'b0;
         end
      end
      bus.imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_chk++;
      if (bus.imem_req !== 1'b0) begin
         n_fail++; $display("FAIL %s_req: got %b, want 0", tag, bus.imem_req);
      end
      n_chk++;
      if (bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s_valid: got %b, want 0", tag, bus.instr_valid);
      end
      n_chk++;
      if (bus.instr !== NOP_INSTR) begin
         n_fail++; $display("FAIL %s_instr: got %h, want %h", tag, bus.instr, NOP_INSTR);
      end
      n_chk++;
      if (bus.instr_pc !== RESET_PC || bus.imem_addr !== RESET_PC) begin
         n_fail++; $display("FAIL %s_pc: got instr_pc=%h addr=%h, want %h", tag, bus.instr_pc, bus.imem_addr, RESET_PC);
      end
   endtask

   // Runs cycles until imem_req is seen; instr_valid must stay low meanwhile.
   task automatic wait_req_flushed(input string tag, input logic [31:0] want_addr);
      int n;
      n = 0;
      while (!bus.imem_req && n < 20) begin
         n_chk++;
         if (bus.instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_dropped: got instr_valid=%b, want 0", tag, bus.instr_valid);
         end
         cycle();
         n++;
      end
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== want_addr) begin
         n_fail++;
         $display("FAIL %s_next_req: got req=%b addr=%h, want req=1 addr=%h", tag, bus.imem_req, bus.imem_addr, want_addr);
      end
   endtask

   task automatic test_reset();
      chk_en = 1'b0; gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
      bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
      rst_n = 1'b0; pend = 1'b0; hold_pend = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      exp_pc = RESET_PC;
      chk_en = 1'b1;
   endtask

   task automatic test_first_fetch();
      n_chk++;
      if (bus.imem_req !== 1'b0) begin
         n_fail++; $display("FAIL c0_idle: got imem_req=%b, want 0", bus.imem_req);
      end
      cycle();
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL c1_req: got req=%b addr=%h, want req=1 addr=0", bus.imem_req, bus.imem_addr);
      end
      cycle();
      n_chk++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL c2_wait: got req=%b valid=%b, want 0 0", bus.imem_req, bus.instr_valid);
      end
      cycle();
      n_chk++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0050_0093 || bus.instr_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL c3_valid: got valid=%b instr=%h pc=%h, want 1 00500093 00000000",
                  bus.instr_valid, bus.instr, bus.instr_pc);
      end
   endtask

   task automatic test_hold();
      bus.instr_ready = 1'b0;
      repeat (5) begin
         cycle();
         n_chk++;
         if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL hold_no_req: got imem_req=%b, want 0", bus.imem_req);
         end
      end
      bus.instr_ready = 1'b1;
      cycle();
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: got req=%b addr=%h valid=%b, want 1 00000004 0",
                  bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
   endtask

   task automatic test_redirect_wait();
      lat_min = 3; lat_max = 3;
      cycle();  // request granted, now waiting with a 3-cycle response
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
      cycle();
      bus.redirect = 1'b0;
      wait_req_flushed("redir_wait", 32'h0000_0100);
      lat_min = 1; lat_max = 1;
   endtask

   task automatic test_redirect_gnt();
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
      cycle();  // granted in the same cycle as the redirect
      bus.redirect = 1'b0;
      wait_req_flushed("redir_gnt", 32'h0000_0200);
   endtask

   task automatic test_wrap();
      int n;
      bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
      cycle();
      bus.redirect = 1'b0;
      acc_q.delete();
      n = 0;
      while (acc_q.size() < 2 && n < 40) begin
         cycle();
         n++;
      end
      n_chk++;
      if (acc_q.size() < 2) begin
         n_fail++; $display("FAIL wrap_timeout: got %0d accepted, want 2", acc_q.size());
      end else if (acc_q[0] !== 32'hFFFF_FFFC || acc_q[1] !== 32'h0000_0000) begin
         n_fail++; $display("FAIL wrap_pcs: got %h %h, want fffffffc 00000000", acc_q[0], acc_q[1]);
      end
   endtask

   task automatic test_reset_mid_wait();
      int n;
      lat_min = 3; lat_max = 3;
      n = 0;
      while (!bus.imem_req && n < 20) begin
         cycle();
         n++;
      end
      cycle();  // now waiting for the response
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      chk_en = 1'b0; pend = 1'b0; hold_pend = 1'b0;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0BAD_C0DE;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      check_reset_outputs("rst_rvalid");
      @(posedge clk);
      #1;
      lat_min = 1; lat_max = 1;
      rst_n = 1'b1;
      exp_pc = RESET_PC;
      acc_q.delete();
      chk_en = 1'b1;
      bus.instr_ready = 1'b1;
      cycle();
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
         n_fail++; $display("FAIL restart_req: got req=%b addr=%h, want 1 %h", bus.imem_req, bus.imem_addr, RESET_PC);
      end
      n = 0;
      while (acc_q.size() < 1 && n < 20) begin
         cycle();
         n++;
      end
      n_chk++;
      if (acc_q.size() < 1 || acc_q[0] !== RESET_PC) begin
         n_fail++; $display("FAIL restart_fetch: got %0d accepted, want first pc %h", acc_q.size(), RESET_PC);
      end
   endtask

   task automatic test_random();
      gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
      acc_q.delete();
      repeat (3000) begin
         bus.instr_ready = 1'($urandom_range(0, 1));
         bus.redirect    = ($urandom_range(0, 9) == 0);
         bus.redirect_pc = $urandom();
         cycle();
      end
      bus.redirect = 1'b0;
      n_chk++;
      if (acc_q.size() < 50) begin
         n_fail++; $display("FAIL random_progress: got %0d accepted, want at least 50", acc_q.size());
      end
      gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_hold();
      test_redirect_wait();
      test_redirect_gnt();
      test_wrap();
      test_random();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
